time_source_ctrl: RTL and testbench
===================================

// Module: time_source_ctrl
// PURPOSE
//  Parametrised successor of the clock control FSM. Arbitrates NUM_SRC external time sources
//  (src 0 = DCF, highest priority) plus manual set; issues load strobes to the clock counter.
//  Drives the LCD time bus and tracks sync loss with a 1 Hz-tick timeout (holdover).
//  Sits between the DCF/aux decoders, SetClock unit, clock counter and LCD driver.
// PARAMETERS
//  TD_W          44   time/date bus width (same packing as DCF decoder)
//  NUM_SRC       2    number of external sync sources, index 0 = highest priority
//  SYNC_TIMEOUT  120  clk_en ticks in SYNCED without active-source update before HOLDOVER
//  SET_DONE      14   SetClock_state_in code meaning "manual entry complete"
// PORTS
//  clk                      in   1          system clock
//  nReset                   in   1          synchronous reset, active low
//  clk_en                   in   1          1 Hz tick, one clk wide
//  SET_in                   in   1          manual-set request (level)
//  src_enable_in            in   NUM_SRC    per-source enable (level)
//  src_set_in               in   NUM_SRC    per-source "new valid timestamp" pulse
//  src_timeAndDate_in       in   NUM_SRC*TD_W  source i at [i*TD_W +: TD_W]
//  SetClock_timeAndDate_in  in   TD_W       manual entry value
//  SetClock_state_in        in   4          SetClock progress code
//  clock_timeAndDate_in     in   TD_W       running clock value
//  STATE_out                out  6          one-hot state
//  LCD_timeAndDate_out      out  TD_W       value to display
//  clock_timeAndDate_out    out  TD_W       value to load into clock
//  clock_set_out            out  1          one-cycle load strobe
//  active_src_out           out  NUM_SRC    one-hot current sync source, 0 if none
//  sync_lost_out            out  1          high in HOLDOVER
// BEHAVIOUR
//  - Reset: state FREE, STATE_out=6'b000001, all data outputs 0, strobe 0, active_src 0,
//    sync_lost 0, tick counter 0. Reset during LOAD: strobe low at that edge, no load.
//  - STATE_out bits: 0 FREE, 1 SET, 2 WAIT, 3 SYNCED, 4 HOLDOVER, 5 LOAD.
//  - Transitions every clk edge; clk_en only advances the tick counter.
//  - Priority each cycle: LOAD completes > SET_in > lowest-index enabled src with set pulse.
//  - FREE: SET_in -> SET; else any src enabled -> WAIT.
//  - SET: SET_in low before done -> FREE, no load. SetClock_state_in==SET_DONE -> LOAD with
//    SetClock value; after LOAD -> WAIT if any src enabled else FREE; active_src cleared.
//  - WAIT: no src enabled -> FREE; src i enabled & set -> LOAD with src i value, then SYNCED,
//    active_src=1<<i.
//  - SYNCED: counter +1 per clk_en, saturates at SYNC_TIMEOUT; active src set pulse -> LOAD,
//    counter 0 (set wins over same-cycle clk_en). Higher-priority enabled src set -> LOAD and
//    switch. Active src disabled -> WAIT if another enabled else FREE. Counter==SYNC_TIMEOUT
//    -> HOLDOVER, sync_lost_out=1.
//  - HOLDOVER: enabled src set -> LOAD->SYNCED, sync_lost 0; SET_in -> SET, sync_lost 0;
//    no src enabled -> FREE, sync_lost 0. Clock free-runs.
//  - Set pulse from a disabled source ignored in all states.
//  - LOAD: exactly one cycle; clock_set_out=1 only here; clock_timeAndDate_out registered on
//    entry, valid with strobe, held until next LOAD. Counter cleared on every LOAD.
//  - LCD_timeAndDate_out registered, 1-cycle latency: SetClock value in SET, else clock value.
// TESTING
//  - nReset low 3 clk -> STATE_out=6'b000001, strobe 0, outputs 0; held after nReset high.
//  - en=2'b01, src_set[0] pulse, src0=44'h0A5... -> next clk LOAD, strobe 1 cycle,
//    clock out=src0, then STATE_out=6'b001000, active_src=2'b01.
//  - SYNCED on src1, src_set=2'b11 same cycle -> loads src0 value, active_src=2'b01.
//  - SYNCED, no set pulse for 120 clk_en ticks -> STATE_out=6'b010000, sync_lost 1;
//    then src_set[0] -> LOAD, SYNCED, sync_lost 0.
//  - SET_in=1, SetClock_state_in=14 -> LOAD with SetClock value; SET_in dropped at state 7
//    -> FREE, no strobe.
//  - SET_in and src_set[0] same cycle in WAIT -> SET entered, no load.

Source files
------------

// File: rtl/time_source_ctrl.sv
// time_source_ctrl: arbitrates NUM_SRC external time sources (index 0 highest
// priority) plus manual entry, issues one-cycle load strobes to the clock
// counter, drives the LCD time bus and tracks sync loss with a tick timeout.
module time_source_ctrl #(
  parameter int TD_W         = 44,
  parameter int NUM_SRC      = 2,
  parameter int SYNC_TIMEOUT = 120,
  parameter int SET_DONE     = 14
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    clk_en,
  input  logic                    SET_in,
  input  logic [NUM_SRC-1:0]      src_enable_in,
  input  logic [NUM_SRC-1:0]      src_set_in,
  input  logic [NUM_SRC*TD_W-1:0] src_timeAndDate_in,
  input  logic [TD_W-1:0]         SetClock_timeAndDate_in,
  input  logic [3:0]              SetClock_state_in,
  input  logic [TD_W-1:0]         clock_timeAndDate_in,
  output logic [5:0]              STATE_out,
  output logic [TD_W-1:0]         LCD_timeAndDate_out,
  output logic [TD_W-1:0]         clock_timeAndDate_out,
  output logic                    clock_set_out,
  output logic [NUM_SRC-1:0]      active_src_out,
  output logic                    sync_lost_out
);

  localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [5:0] {
    S_FREE     = 6'b000001,
    S_SET      = 6'b000010,
    S_WAIT     = 6'b000100,
    S_SYNCED   = 6'b001000,
    S_HOLDOVER = 6'b010000,
    S_LOAD     = 6'b100000
  } state_t;

  state_t               state_q, state_d;
  logic [TD_W-1:0]      ctd_q, ctd_d;
  logic [TD_W-1:0]      lcd_q, lcd_d;
  logic [NUM_SRC-1:0]   act_q, act_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ld_src_q, ld_src_d;  // 1: source load -> SYNCED, 0: manual load

  logic [NUM_SRC-1:0]   hit;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic [TD_W-1:0]      hit_td;
  logic [NUM_SRC-1:0]   hit_oh;
  logic                 any_en, act_en, preempt;

  // Lowest-index enabled source that pulsed set this cycle, and its value.
  always_comb begin
    hit     = src_enable_in & src_set_in;
    hit_any = 1'b0;
    hit_idx = '0;
    hit_td  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hit_idx == IDX_W'(i)) hit_td = src_timeAndDate_in[i*TD_W +: TD_W];
    end
    hit_oh  = NUM_SRC'(1) << hit_idx;
    any_en  = |src_enable_in;
    act_en  = |(act_q & src_enable_in);
    // One-hot masks: smaller value means higher priority, so this accepts the
    // active source itself or any higher-priority one.
    preempt = hit_any && (hit_oh <= act_q);
  end

  // Next-state logic: LOAD completion first, then SET_in, then source pulses.
  always_comb begin
    state_d  = state_q;
    ctd_d    = ctd_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    ld_src_d = ld_src_q;
    unique case (state_q)
      S_FREE: begin
        if (SET_in)      state_d = S_SET;
        else if (any_en) state_d = S_WAIT;
      end
      S_SET: begin
        if (!SET_in) begin
          state_d = S_FREE;
          act_d   = '0;
        end else if (SetClock_state_in == 4'(SET_DONE)) begin
          state_d  = S_LOAD;
          ctd_d    = SetClock_timeAndDate_in;
          act_d    = '0;
          ld_src_d = 1'b0;
          cnt_d    = '0;
        end
      end
      S_WAIT: begin
        if (SET_in) begin
          state_d = S_SET;
          act_d   = '0;
        end else if (!any_en) begin
          state_d = S_FREE;
          act_d   = '0;
        end else if (hit_any) begin
          state_d  = S_LOAD;
          ctd_d    = hit_td;
          act_d    = hit_oh;
          ld_src_d = 1'b1;
          cnt_d    = '0;
        end
      end
      S_SYNCED: begin
        if (SET_in) begin
          state_d = S_SET;
          act_d   = '0;
        end else if (preempt) begin
          // A fresh timestamp wins over a same-cycle tick.
          state_d  = S_LOAD;
          ctd_d    = hit_td;
          act_d    = hit_oh;
          ld_src_d = 1'b1;
          cnt_d    = '0;
        end else if (!act_en) begin
          state_d = any_en ? S_WAIT : S_FREE;
          act_d   = '0;
        end else if (cnt_q == CNT_W'(SYNC_TIMEOUT)) begin
          state_d = S_HOLDOVER;
        end else if (clk_en && cnt_q < CNT_W'(SYNC_TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLDOVER: begin
        if (SET_in) begin
          state_d = S_SET;
          act_d   = '0;
        end else if (!any_en) begin
          state_d = S_FREE;
          act_d   = '0;
        end else if (hit_any) begin
          state_d  = S_LOAD;
          ctd_d    = hit_td;
          act_d    = hit_oh;
          ld_src_d = 1'b1;
          cnt_d    = '0;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        if (ld_src_q)    state_d = S_SYNCED;
        else if (any_en) state_d = S_WAIT;
        else             state_d = S_FREE;
      end
      default: begin
        state_d = S_FREE;
        act_d   = '0;
        cnt_d   = '0;
      end
    endcase
    lcd_d = (state_q == S_SET) ? SetClock_timeAndDate_in : clock_timeAndDate_in;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q  <= S_FREE;
      ctd_q    <= '0;
      lcd_q    <= '0;
      act_q    <= '0;
      cnt_q    <= '0;
      ld_src_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctd_q    <= ctd_d;
      lcd_q    <= lcd_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      ld_src_q <= ld_src_d;
    end
  end

  assign STATE_out             = state_q;
  assign LCD_timeAndDate_out   = lcd_q;
  assign clock_timeAndDate_out = ctd_q;
  assign clock_set_out         = (state_q == S_LOAD);
  assign active_src_out        = act_q;
  assign sync_lost_out         = (state_q == S_HOLDOVER);

endmodule

// File: tb/tb_time_source_ctrl.sv
// Table-driven bench for time_source_ctrl with an expectation queue.
module tb_time_source_ctrl;

  localparam int TD_W = 44;
  localparam int NS   = 2;

  localparam logic [5:0] FR = 6'b000001, ST = 6'b000010, WT = 6'b000100,
                         SY = 6'b001000, HO = 6'b010000, LD = 6'b100000;
  localparam logic [TD_W-1:0] VA = 44'h0A55A5A5A5A;
  localparam logic [TD_W-1:0] VB = 44'h0B123456789;
  localparam logic [TD_W-1:0] VM = 44'h0C0FFEE0001;
  localparam logic [TD_W-1:0] VC = 44'h0D000001234;

  logic              clk = 1'b0;
  logic              nReset, clk_en, SET_in;
  logic [NS-1:0]     src_enable_in, src_set_in;
  logic [NS*TD_W-1:0] src_timeAndDate_in;
  logic [TD_W-1:0]   SetClock_timeAndDate_in, clock_timeAndDate_in;
  logic [3:0]        SetClock_state_in;
  logic [5:0]        STATE_out;
  logic [TD_W-1:0]   LCD_timeAndDate_out, clock_timeAndDate_out;
  logic              clock_set_out, sync_lost_out;
  logic [NS-1:0]     active_src_out;

  int checks = 0;
  int failures = 0;

  time_source_ctrl dut (
    .clk(clk), .nReset(nReset), .clk_en(clk_en), .SET_in(SET_in),
    .src_enable_in(src_enable_in), .src_set_in(src_set_in),
    .src_timeAndDate_in(src_timeAndDate_in),
    .SetClock_timeAndDate_in(SetClock_timeAndDate_in),
    .SetClock_state_in(SetClock_state_in),
    .clock_timeAndDate_in(clock_timeAndDate_in),
    .STATE_out(STATE_out), .LCD_timeAndDate_out(LCD_timeAndDate_out),
    .clock_timeAndDate_out(clock_timeAndDate_out), .clock_set_out(clock_set_out),
    .active_src_out(active_src_out), .sync_lost_out(sync_lost_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            rst_n, set, ce;
    logic [NS-1:0]   en, sset;
    logic [3:0]      sc;
    logic [5:0]      e_st;
    logic            e_stb, e_lost;
    logic [NS-1:0]   e_act;
    logic [TD_W-1:0] e_ctd, e_lcd;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[26];

  function automatic vec_t mk(string n, logic r, logic s, logic [NS-1:0] en,
                              logic [NS-1:0] ss, logic [3:0] sc, logic ce,
                              logic [5:0] st, logic stb, logic [NS-1:0] act,
                              logic lost, logic [TD_W-1:0] ctd, logic [TD_W-1:0] lcd);
    vec_t v;
    v.name = n; v.rst_n = r; v.set = s; v.en = en; v.sset = ss; v.sc = sc; v.ce = ce;
    v.e_st = st; v.e_stb = stb; v.e_act = act; v.e_lost = lost; v.e_ctd = ctd; v.e_lcd = lcd;
    return v;
  endfunction

  task automatic chk(string n, logic [TD_W-1:0] act, logic [TD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic step(vec_t v);
    vec_t e;
    @(negedge clk);
    nReset = v.rst_n; SET_in = v.set; src_enable_in = v.en; src_set_in = v.sset;
    SetClock_state_in = v.sc; clk_en = v.ce;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".state"},  TD_W'(STATE_out),      TD_W'(e.e_st));
    chk({e.name, ".strobe"}, TD_W'(clock_set_out),  TD_W'(e.e_stb));
    chk({e.name, ".active"}, TD_W'(active_src_out), TD_W'(e.e_act));
    chk({e.name, ".lost"},   TD_W'(sync_lost_out),  TD_W'(e.e_lost));
    chk({e.name, ".clk_td"}, clock_timeAndDate_out, e.e_ctd);
    chk({e.name, ".lcd"},    LCD_timeAndDate_out,   e.e_lcd);
  endtask

  initial begin
    nReset = 1'b0; clk_en = 1'b0; SET_in = 1'b0; src_enable_in = '0; src_set_in = '0;
    SetClock_state_in = '0;
    src_timeAndDate_in = {VB, VA};
    SetClock_timeAndDate_in = VM;
    clock_timeAndDate_in = VC;

    //              name     rst set en     sset  sc  ce  state stb act  lost ctd lcd
    tbl[0]  = mk("idle",     1, 0, 2'b00, 2'b00, 0, 0, FR, 0, 2'b00, 0, 0,  VC);
    tbl[1]  = mk("en0",      1, 0, 2'b01, 2'b00, 0, 0, WT, 0, 2'b00, 0, 0,  VC);
    tbl[2]  = mk("ld0",      1, 0, 2'b01, 2'b01, 0, 0, LD, 1, 2'b01, 0, VA, VC);
    tbl[3]  = mk("sync0",    1, 0, 2'b01, 2'b00, 0, 0, SY, 0, 2'b01, 0, VA, VC);
    tbl[4]  = mk("lowign",   1, 0, 2'b11, 2'b10, 0, 0, SY, 0, 2'b01, 0, VA, VC);
    tbl[5]  = mk("actdis",   1, 0, 2'b10, 2'b00, 0, 0, WT, 0, 2'b00, 0, VA, VC);
    tbl[6]  = mk("ld1",      1, 0, 2'b11, 2'b10, 0, 0, LD, 1, 2'b10, 0, VB, VC);
    tbl[7]  = mk("sync1",    1, 0, 2'b11, 2'b00, 0, 0, SY, 0, 2'b10, 0, VB, VC);
    tbl[8]  = mk("both",     1, 0, 2'b11, 2'b11, 0, 0, LD, 1, 2'b01, 0, VA, VC);
    tbl[9]  = mk("sw0",      1, 0, 2'b11, 2'b00, 0, 0, SY, 0, 2'b01, 0, VA, VC);
    tbl[10] = mk("lowign2",  1, 0, 2'b11, 2'b10, 0, 1, SY, 0, 2'b01, 0, VA, VC);
    tbl[11] = mk("alldis",   1, 0, 2'b00, 2'b00, 0, 0, FR, 0, 2'b00, 0, VA, VC);
    tbl[12] = mk("wait",     1, 0, 2'b01, 2'b00, 0, 0, WT, 0, 2'b00, 0, VA, VC);
    tbl[13] = mk("setvsrc",  1, 1, 2'b01, 2'b01, 0, 0, ST, 0, 2'b00, 0, VA, VC);
    tbl[14] = mk("set7",     1, 1, 2'b01, 2'b00, 7, 0, ST, 0, 2'b00, 0, VA, VM);
    tbl[15] = mk("setdone",  1, 1, 2'b01, 2'b00, 14,0, LD, 1, 2'b00, 0, VM, VM);
    tbl[16] = mk("mwait",    1, 0, 2'b01, 2'b00, 14,0, WT, 0, 2'b00, 0, VM, VC);
    tbl[17] = mk("set3",     1, 1, 2'b00, 2'b00, 3, 0, ST, 0, 2'b00, 0, VM, VC);
    tbl[18] = mk("set7b",    1, 1, 2'b00, 2'b00, 7, 0, ST, 0, 2'b00, 0, VM, VM);
    tbl[19] = mk("abort",    1, 0, 2'b00, 2'b00, 7, 0, FR, 0, 2'b00, 0, VM, VM);
    tbl[20] = mk("set14",    1, 1, 2'b00, 2'b00, 14,0, ST, 0, 2'b00, 0, VM, VC);
    tbl[21] = mk("mload",    1, 1, 2'b00, 2'b00, 14,0, LD, 1, 2'b00, 0, VM, VM);
    tbl[22] = mk("mfree",    1, 0, 2'b00, 2'b00, 0, 0, FR, 0, 2'b00, 0, VM, VC);
    tbl[23] = mk("disign",   1, 0, 2'b00, 2'b01, 0, 0, FR, 0, 2'b00, 0, VM, VC);
    tbl[24] = mk("disign2",  1, 0, 2'b10, 2'b01, 0, 0, WT, 0, 2'b00, 0, VM, VC);
    tbl[25] = mk("disign3",  1, 0, 2'b10, 2'b01, 0, 0, WT, 0, 2'b00, 0, VM, VC);

    // Reset held three clocks.
    for (int i = 0; i < 3; i++)
      step(mk("rst", 0, 0, 2'b00, 2'b00, 0, 0, FR, 0, 2'b00, 0, 0, 0));

    for (int i = 0; i < 26; i++) step(tbl[i]);

    // Timeout into HOLDOVER on source 1, then recovery via source 0.
    step(mk("ldB",  1, 0, 2'b10, 2'b10, 0, 0, LD, 1, 2'b10, 0, VB, VC));
    step(mk("syB",  1, 0, 2'b10, 2'b00, 0, 0, SY, 0, 2'b10, 0, VB, VC));
    for (int i = 0; i < 120; i++)
      step(mk("tick", 1, 0, 2'b10, 2'b00, 0, 1, SY, 0, 2'b10, 0, VB, VC));
    step(mk("hold",  1, 0, 2'b10, 2'b00, 0, 0, HO, 0, 2'b10, 1, VB, VC));
    step(mk("hold2", 1, 0, 2'b10, 2'b00, 0, 1, HO, 0, 2'b10, 1, VB, VC));
    step(mk("hldA",  1, 0, 2'b11, 2'b01, 0, 0, LD, 1, 2'b01, 0, VA, VC));
    step(mk("syA",   1, 0, 2'b11, 2'b00, 0, 0, SY, 0, 2'b01, 0, VA, VC));

    // Reset arriving while in LOAD suppresses the strobe and clears outputs.
    step(mk("ldR",   1, 0, 2'b11, 2'b10, 0, 0, SY, 0, 2'b01, 0, VA, VC));
    step(mk("ldR2",  1, 0, 2'b11, 2'b01, 0, 0, LD, 1, 2'b01, 0, VA, VC));
    step(mk("rstld", 0, 0, 2'b11, 2'b00, 0, 0, FR, 0, 2'b00, 0, 0,  0));
    step(mk("post",  1, 0, 2'b00, 2'b00, 0, 0, FR, 0, 2'b00, 0, 0,  VC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
